// File: rtl/cordic_pkg.sv
// Shared constants, field widths, FSM state type and arctangent table
// for the rotation-mode CORDIC.
package cordic_pkg;

    localparam int AMP_W = 12;
    localparam int PH_W  = 14;
    localparam int XY_W  = 12;

    localparam logic signed [PH_W-1:0] PI      = 14'sd3217;
    localparam logic signed [PH_W-1:0] PI_HALF = 14'sd1608;

    // 0.60725 in Q0.12, inverse of the CORDIC gain
    localparam logic [AMP_W-1:0] K_GAIN = 12'd2487;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        ITER,
        DONE
    } state_t;

    // atan(2^-i) in Q3.10 radians
    function automatic logic signed [PH_W-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 14'sd804;
            4'd1:    return 14'sd475;
            4'd2:    return 14'sd251;
            4'd3:    return 14'sd127;
            4'd4:    return 14'sd64;
            4'd5:    return 14'sd32;
            4'd6:    return 14'sd16;
            4'd7:    return 14'sd8;
            4'd8:    return 14'sd4;
            4'd9:    return 14'sd2;
            4'd10:   return 14'sd1;
            default: return 14'sd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// One combinational CORDIC micro-rotation in rotation mode: the sign of
// the residual angle picks the rotation direction for step i.
module cordic_rot_step
    import cordic_pkg::*;
#(
    parameter int W_INT = 16
) (
    input  logic signed [W_INT-1:0] i_x,
    input  logic signed [W_INT-1:0] i_y,
    input  logic signed [PH_W-1:0]  i_z,
    input  logic        [3:0]       i_iter,
    output logic signed [W_INT-1:0] o_x,
    output logic signed [W_INT-1:0] o_y,
    output logic signed [PH_W-1:0]  o_z
);

    logic                    w_dpos;
    logic signed [W_INT-1:0] w_xs;
    logic signed [W_INT-1:0] w_ys;
    logic signed [PH_W-1:0]  w_atan;

    assign w_dpos = ~i_z[PH_W-1];
    assign w_xs   = i_x >>> i_iter;
    assign w_ys   = i_y >>> i_iter;
    assign w_atan = atan_lut(i_iter);

    // Rotate towards zero residual angle; z wraps in 14 bits
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (w_dpos) begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - w_atan;
        end else begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + w_atan;
        end
    end

endmodule

// File: rtl/cordic_rotation_axis.sv
// Rotation-mode CORDIC with AXI-Stream in/out: {Amp, Phase} -> {X, Y}.
// Iterative core, one micro-rotation per clock, one sample in flight.
module cordic_rotation_axis
    import cordic_pkg::*;
#(
    parameter int N_ITER = 12,
    parameter int W_INT  = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata
);

    localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);
    localparam logic signed [W_INT-1:0] XY_MAX = W_INT'(2047);
    localparam logic signed [W_INT-1:0] XY_MIN = -W_INT'(2048);

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [AMP_W-1:0]        r_amp;
    logic signed [PH_W-1:0]  r_phase;
    logic signed [W_INT-1:0] r_x;
    logic signed [W_INT-1:0] r_y;
    logic signed [PH_W-1:0]  r_z;
    logic                    r_tvalid;
    logic [31:0]             r_tdata;

    logic [23:0]             w_prod;
    logic signed [W_INT-1:0] w_gain;
    logic                    w_fold_pos;
    logic                    w_fold_neg;
    logic signed [W_INT-1:0] w_x0;
    logic signed [PH_W-1:0]  w_z0;
    logic signed [W_INT-1:0] w_step_x;
    logic signed [W_INT-1:0] w_step_y;
    logic signed [PH_W-1:0]  w_step_z;
    logic                    w_unused_bits;

    function automatic logic [XY_W-1:0] f_sat(input logic signed [W_INT-1:0] v);
        if (v > XY_MAX) return XY_MAX[XY_W-1:0];
        if (v < XY_MIN) return XY_MIN[XY_W-1:0];
        return v[XY_W-1:0];
    endfunction

    assign s_axis_tready = (r_state == IDLE) && RSTN;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;

    // Gain compensation rounded half-up: (Amp*K + 2^11) >> 12, at most 2486
    assign w_prod = {12'd0, r_amp} * {12'd0, K_GAIN} + 24'd2048;
    assign w_gain = $signed({{(W_INT-AMP_W){1'b0}}, w_prod[23:12]});

    // Fold phases beyond +-pi/2 into the CORDIC convergence range
    assign w_fold_pos = (r_phase > PI_HALF);
    assign w_fold_neg = (r_phase < -PI_HALF);
    assign w_x0 = (w_fold_pos || w_fold_neg) ? -w_gain : w_gain;
    assign w_z0 = w_fold_pos ? (r_phase - PI) :
                  w_fold_neg ? (r_phase + PI) : r_phase;

    assign w_unused_bits = ^{s_axis_tdata[31:28], s_axis_tdata[15:14], w_prod[11:0]};

    cordic_rot_step #(
        .W_INT(W_INT)
    ) u_step (
        .i_x   (r_x),
        .i_y   (r_y),
        .i_z   (r_z),
        .i_iter(r_cnt),
        .o_x   (w_step_x),
        .o_y   (w_step_y),
        .o_z   (w_step_z)
    );

    // Sample FSM: capture, initialise, iterate, hold result until taken.
    // The final micro-rotation is saturated straight into the output register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        r_amp   <= s_axis_tdata[27:16];
                        r_phase <= $signed(s_axis_tdata[13:0]);
                        r_state <= PRE;
                    end
                end
                PRE: begin
                    r_x     <= w_x0;
                    r_y     <= '0;
                    r_z     <= w_z0;
                    r_cnt   <= '0;
                    r_state <= ITER;
                end
                ITER: begin
                    r_x <= w_step_x;
                    r_y <= w_step_y;
                    r_z <= w_step_z;
                    if (r_cnt == LAST_ITER) begin
                        r_tdata  <= {4'd0, f_sat(w_step_x), 4'd0, f_sat(w_step_y)};
                        r_tvalid <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (m_axis_tready) begin
                        r_tvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotation_axis.sv
// Directed bench for cordic_rotation_axis: known polar points, saturation,
// zero amplitude, latency/throughput, back-pressure and mid-run reset.
module tb_cordic_rotation_axis;

    localparam int N_ITER = 12;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;

    int n_chk = 0;
    int n_err = 0;

    int          edge_cnt = 0;
    int          acc_edge[$];
    int          out_edge[$];
    logic [31:0] out_data[$];

    cordic_rotation_axis #(
        .N_ITER(N_ITER),
        .W_INT (16)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata (s_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata (m_tdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt++;

    // Handshakes are decided by values stable at the falling edge
    always @(negedge CLK) begin
        if (RSTN && s_tvalid && s_tready) acc_edge.push_back(edge_cnt + 1);
        if (RSTN && m_tvalid && m_tready) begin
            out_edge.push_back(edge_cnt + 1);
            out_data.push_back(m_tdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp, input int tol);
        int diff;
        n_chk++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int sx12(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    task automatic send(input int amp, input int ph);
        bit done = 0;
        s_tdata  = {4'd0, amp[11:0], 2'd0, ph[13:0]};
        s_tvalid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge CLK);
            if (s_tready) begin
                @(posedge CLK);
                #1;
                done = 1;
            end
        end
        s_tvalid = 1'b0;
        if (!done) check("send_timeout", 0, 1, 0);
    endtask

    task automatic recv(output logic [31:0] d);
        bit done = 0;
        d = '0;
        m_tready = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge CLK);
            if (m_tvalid) begin
                d = m_tdata;
                @(posedge CLK);
                #1;
                done = 1;
            end
        end
        if (!done) check("recv_timeout", 0, 1, 0);
    endtask

    task automatic run_vec(input string tag, input int amp, input int ph,
                           input int ex, input int ey, input int tolx, input int toly);
        logic [31:0] d;
        send(amp, ph);
        recv(d);
        check({tag, "_x"}, sx12(d[27:16]), ex, tolx);
        check({tag, "_y"}, sx12(d[11:0]), ey, toly);
        check({tag, "_pad"}, int'({d[31:28], d[15:12]}), 0, 0);
    endtask

    initial begin
        int          a0;
        int          n_acc;
        int          n_out;
        int          bad;
        bit          seen;
        logic [31:0] d0;
        logic [31:0] d;

        RSTN     = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_mvalid", int'(m_tvalid), 0, 0);
        check("rst_mdata", int'(m_tdata), 0, 0);
        check("rst_sready", int'(s_tready), 0, 0);
        RSTN = 1'b1;
        @(negedge CLK);
        check("idle_sready", int'(s_tready), 1, 0);
        @(posedge CLK);
        #1;

        // Polar points; traces of the fixed-point iteration land within 3 LSB
        run_vec("ph0", 1000, 0, 1000, 0, 3, 3);
        run_vec("ph_pi2", 1000, 1608, 0, 1000, 3, 3);
        run_vec("ph_mpi", 1000, -3217, -1000, 0, 3, 3);
        run_vec("ph_mpi2", 1000, -1608, 0, -1000, 3, 3);
        run_vec("ph_pi", 1000, 3217, -1000, 0, 3, 3);
        run_vec("amp0", 0, 1000, 0, 0, 0, 0);
        // Full scale: X clips exactly; the last residual angle is scaled by
        // amplitude, so Y lands 4 LSB off here
        run_vec("sat", 4095, 0, 2047, 0, 0, 4);

        // Back-to-back stream with sink always ready
        n_acc = acc_edge.size();
        n_out = out_edge.size();
        m_tready = 1'b1;
        s_tdata  = {4'd0, 12'd1000, 2'd0, 14'd0};
        s_tvalid = 1'b1;
        repeat (3 * (N_ITER + 3)) @(posedge CLK);
        #1;
        s_tvalid = 1'b0;
        repeat (N_ITER + 6) @(posedge CLK);
        #1;
        check("stream_acc", acc_edge.size() - n_acc, 3, 0);
        check("stream_out", out_edge.size() - n_out, 3, 0);
        if (acc_edge.size() >= n_acc + 2 && out_edge.size() >= n_out + 1) begin
            a0 = acc_edge[n_acc];
            check("latency", out_edge[n_out] - a0, N_ITER + 2, 0);
            check("period", acc_edge[n_acc + 1] - a0, N_ITER + 3, 0);
        end

        // Back-pressure: result held, input blocked, then a single transfer
        m_tready = 1'b0;
        send(1000, 1608);
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge CLK);
            if (m_tvalid) seen = 1;
        end
        check("bp_valid", int'(seen), 1, 0);
        d0 = m_tdata;
        n_out = out_data.size();
        bad = 0;
        @(posedge CLK);
        #1;
        s_tdata  = {4'd0, 12'd500, 2'd0, 14'd100};
        s_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!m_tvalid || m_tdata != d0 || s_tready) bad++;
        end
        check("bp_stable", bad, 0, 0);
        @(posedge CLK);
        #1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        check("bp_one_xfer", out_data.size() - n_out, 1, 0);
        if (out_data.size() > n_out) check("bp_data", int'(out_data[n_out]), int'(d0), 0);
        check("bp_xfer_y", sx12(d0[11:0]), 1000, 3);

        // Reset pulse while the iteration counter sits at 5
        send(1000, 0);
        repeat (6) @(posedge CLK);
        #1;
        RSTN = 1'b0;
        @(negedge CLK);
        check("rstmid_sready_low", int'(s_tready), 0, 0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(negedge CLK);
        check("rstmid_mvalid", int'(m_tvalid), 0, 0);
        check("rstmid_mdata", int'(m_tdata), 0, 0);
        check("rstmid_sready", int'(s_tready), 1, 0);
        n_out = out_data.size();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (m_tvalid) bad++;
        end
        check("rstmid_no_out", bad + out_data.size() - n_out, 0, 0);
        @(posedge CLK);
        #1;
        run_vec("post_rst", 1000, 0, 1000, 0, 3, 3);

        // Out-of-range phase must still produce exactly one result
        n_out = out_data.size();
        send(1000, 8000);
        recv(d);
        check("oor_done", out_data.size() - n_out, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
